// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: start/stop measurement sequencer feeding the T0 calculator, burst of cfg_num results.
// Optional stop-wait timeout built when TDC_TIMEOUT_EN is defined.
module tdc_meas_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int TO_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [CNT_WIDTH-1:0]  cfg_num,
    input  logic [TO_WIDTH-1:0]   cfg_timeout,
    input  logic                  hit_start,
    input  logic [DATA_WIDTH-1:0] start_coarse,
    input  logic [DATA_WIDTH-1:0] start_fine,
    input  logic                  hit_stop,
    input  logic [DATA_WIDTH-1:0] stop_coarse,
    input  logic [DATA_WIDTH-1:0] stop_fine,
    output logic                  calc_start_en,
    output logic                  calc_stop_en,
    output logic [DATA_WIDTH-1:0] calc_start_coarse,
    output logic [DATA_WIDTH-1:0] calc_start_fine,
    output logic [DATA_WIDTH-1:0] calc_stop_coarse,
    output logic [DATA_WIDTH-1:0] calc_stop_fine,
    input  logic                  calc_valid,
    input  logic [DATA_WIDTH-1:0] calc_data,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_timeout,
    output logic [CNT_WIDTH-1:0]  meas_cnt,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, WAIT} state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_num, w_cnt_inc;
    logic                 w_load, w_start_ev, w_stop_ev, w_to_ev, w_res_ev, w_last;

    assign w_load     = r_state == IDLE && cfg_start;
    assign w_start_ev = r_state == ARMED && !cfg_abort && hit_start;
    assign w_stop_ev  = r_state == RUN && !cfg_abort && hit_stop;
    assign w_res_ev   = r_state == WAIT && !cfg_abort && calc_valid;
    assign w_cnt_inc  = &meas_cnt ? meas_cnt : meas_cnt + CNT_WIDTH'(1);
    assign w_last     = w_cnt_inc == r_num;
    assign busy       = r_state != IDLE;

`ifdef TDC_TIMEOUT_EN
    logic [TO_WIDTH-1:0] r_to, r_to_cnt;

    // Fires when the count would reach the limit; a stop hit in that cycle wins.
    assign w_to_ev = r_state == RUN && !cfg_abort && !hit_stop && r_to != '0 &&
                     r_to_cnt + TO_WIDTH'(1) == r_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to     <= '0;
            r_to_cnt <= '0;
        end else begin
            if (w_load) r_to <= cfg_timeout;
            r_to_cnt <= w_start_ev ? '0 : r_state == RUN ? r_to_cnt + TO_WIDTH'(1) : r_to_cnt;
        end
    end
`else
    assign w_to_ev = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state != IDLE && cfg_abort) w_state_nxt = IDLE;
        else begin
            case (r_state)
                IDLE:    w_state_nxt = cfg_start ? ARMED : IDLE;
                ARMED:   w_state_nxt = w_start_ev ? RUN : ARMED;
                RUN:     w_state_nxt = w_stop_ev ? WAIT : w_to_ev ? (w_last ? IDLE : ARMED) : RUN;
                WAIT:    w_state_nxt = w_res_ev ? (w_last ? IDLE : ARMED) : WAIT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num             <= '0;
            meas_cnt          <= '0;
            calc_start_en     <= 1'b0;
            calc_stop_en      <= 1'b0;
            calc_start_coarse <= '0;
            calc_start_fine   <= '0;
            calc_stop_coarse  <= '0;
            calc_stop_fine    <= '0;
            res_valid         <= 1'b0;
            res_data          <= '0;
            res_timeout       <= 1'b0;
            done              <= 1'b0;
        end else begin
            calc_start_en <= w_start_ev;
            calc_stop_en  <= w_stop_ev;
            res_valid     <= w_res_ev || w_to_ev;
            res_timeout   <= w_to_ev;
            done          <= (w_res_ev || w_to_ev) && w_last;
            if (w_load) begin
                r_num    <= cfg_num == '0 ? CNT_WIDTH'(1) : cfg_num;
                meas_cnt <= '0;
            end
            if (w_start_ev) begin
                calc_start_coarse <= start_coarse;
                calc_start_fine   <= start_fine;
            end
            if (w_stop_ev) begin
                calc_stop_coarse <= stop_coarse;
                calc_stop_fine   <= stop_fine;
            end
            if (w_res_ev) res_data <= calc_data;
            if (w_to_ev) res_data <= '1;
            if (w_res_ev || w_to_ev) meas_cnt <= w_cnt_inc;
        end
    end
endmodule
